mc_control_unit: RTL

//  Multi-cycle MIPS control FSM; drives the existing 4-bit ALU op code (aluc) and datapath enables.

---
 rtl/mc_control_unit_if.sv | 36 +++
 rtl/mc_control_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields, ALU/memory status in, control word out.
interface mc_control_unit_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       is_zero;
  logic       mem_ready;
  logic [3:0] aluc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic       sext;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pcsource;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] wb_sel;
  logic       illegal;
  logic       bus_err;

  // Control unit side
  modport master (
    input  op, func, is_zero, mem_ready,
    output aluc, alusrca, alusrcb, sext, iord, mem_read, mem_write, ir_write,
           pc_write, pcsource, reg_write, reg_dst, wb_sel, illegal, bus_err
  );

  // Datapath side
  modport slave (
    output op, func, is_zero, mem_ready,
    input  aluc, alusrca, alusrcb, sext, iord, mem_read, mem_write, ir_write,
           pc_write, pcsource, reg_write, reg_dst, wb_sel, illegal, bus_err
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM. Control word is decoded from state plus IR
// fields / ALU zero / memory ready; memory states are guarded by a timeout.
module mc_control_unit #(
  parameter int WAIT_LIMIT = 16
) (
  input logic             clk,
  input logic             rst,
  mc_control_unit_if.master bus
);
  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d,
                         OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08,
                         F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_JR
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_wait;
  logic          w_mem_state, w_timeout;

  logic [3:0] w_aluc;
  logic [1:0] w_alusrca, w_alusrcb, w_pcsource, w_reg_dst, w_wb_sel;
  logic       w_sext, w_iord, w_mem_read, w_mem_write, w_ir_write, w_pc_write;
  logic       w_reg_write, w_illegal, w_bus_err;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // Timeout fires once the counter has accumulated WAIT_LIMIT not-ready cycles.
  assign w_timeout   = (WAIT_LIMIT != 0) && w_mem_state && (r_wait == LIMIT);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Wait counter: restarts on every state change (and on timeout re-entry to FETCH)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_wait <= '0;
    else if (w_timeout || (w_next != r_state))          r_wait <= '0;
    else if (w_mem_state && !bus.mem_ready && (WAIT_LIMIT != 0)) r_wait <= r_wait + 1'b1;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_timeout) w_next = S_FETCH;
                  else if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_R:                                   w_next = (bus.func == F_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_next = S_EXEC_I;
          OP_LW, OP_SW:                           w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                         w_next = S_BRANCH;
          OP_J, OP_JAL:                           w_next = S_JUMP;
          default:                                w_next = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        case (bus.func)
          F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SRA: w_next = S_WB_R;
          default:                                              w_next = S_FETCH;
        endcase
      end
      S_EXEC_I:   w_next = S_WB_R;
      S_MEM_ADDR: w_next = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (w_timeout) w_next = S_FETCH;
                  else if (bus.mem_ready) w_next = S_WB_MEM;
      S_MEM_WR:   if (w_timeout || bus.mem_ready) w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  // Control word decode; everything forced quiet while reset is asserted
  always_comb begin
    w_aluc = 4'b0000; w_alusrca = 2'b00; w_alusrcb = 2'b00; w_sext = 1'b0;
    w_iord = 1'b0; w_mem_read = 1'b0; w_mem_write = 1'b0; w_ir_write = 1'b0;
    w_pc_write = 1'b0; w_pcsource = 2'b00; w_reg_write = 1'b0; w_reg_dst = 2'b00;
    w_wb_sel = 2'b00; w_illegal = 1'b0; w_bus_err = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          if (w_timeout) w_bus_err = 1'b1;
          else begin
            w_mem_read = 1'b1;
            w_alusrcb  = 2'b01;
            if (bus.mem_ready) begin
              w_ir_write = 1'b1;
              w_pc_write = 1'b1;
            end
          end
        end
        S_DECODE: begin
          w_alusrcb = 2'b11;
          case (bus.op)
            OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J, OP_JAL: w_illegal = 1'b0;
            default:                      w_illegal = 1'b1;
          endcase
        end
        S_EXEC_R: begin
          case (bus.func)
            F_ADD: w_alusrca = 2'b01;
            F_SUB: begin w_alusrca = 2'b01; w_aluc = 4'b0100; end
            F_AND: begin w_alusrca = 2'b01; w_aluc = 4'b0001; end
            F_OR:  begin w_alusrca = 2'b01; w_aluc = 4'b0101; end
            F_XOR: begin w_alusrca = 2'b01; w_aluc = 4'b0010; end
            F_SLL: begin w_alusrca = 2'b10; w_aluc = 4'b0011; end
            F_SRL: begin w_alusrca = 2'b10; w_aluc = 4'b0111; end
            F_SRA: begin w_alusrca = 2'b10; w_aluc = 4'b1111; end
            default: w_illegal = 1'b1;
          endcase
        end
        S_EXEC_I: begin
          w_alusrca = 2'b01;
          w_alusrcb = 2'b10;
          case (bus.op)
            OP_ADDI: w_sext = 1'b1;
            OP_ANDI: w_aluc = 4'b0001;
            OP_ORI:  w_aluc = 4'b0101;
            OP_XORI: w_aluc = 4'b0010;
            OP_LUI:  w_aluc = 4'b0110;
            default: w_aluc = 4'b0000;
          endcase
        end
        S_WB_R: begin
          w_reg_write = 1'b1;
          // op is still held from the IR, so it tells R-type from I-type here
          w_reg_dst   = (bus.op == OP_R) ? 2'b01 : 2'b00;
        end
        S_MEM_ADDR: begin
          w_alusrca = 2'b01;
          w_alusrcb = 2'b10;
          w_sext    = 1'b1;
        end
        S_MEM_RD: begin
          if (w_timeout) w_bus_err = 1'b1;
          else begin w_iord = 1'b1; w_mem_read = 1'b1; end
        end
        S_MEM_WR: begin
          if (w_timeout) w_bus_err = 1'b1;
          else begin w_iord = 1'b1; w_mem_write = 1'b1; end
        end
        S_WB_MEM: begin
          w_reg_write = 1'b1;
          w_wb_sel    = 2'b01;
        end
        S_BRANCH: begin
          w_alusrca  = 2'b01;
          w_aluc     = 4'b0100;
          w_pcsource = 2'b01;
          w_pc_write = (bus.op == OP_BNE) ? ~bus.is_zero : bus.is_zero;
        end
        S_JUMP: begin
          w_pcsource = 2'b10;
          w_pc_write = 1'b1;
          if (bus.op == OP_JAL) begin
            w_reg_write = 1'b1;
            w_reg_dst   = 2'b10;
            w_wb_sel    = 2'b10;
          end
        end
        S_JR: begin
          w_pcsource = 2'b11;
          w_pc_write = 1'b1;
        end
        default: w_illegal = 1'b0;
      endcase
    end
  end

  assign bus.aluc      = w_aluc;
  assign bus.alusrca   = w_alusrca;
  assign bus.alusrcb   = w_alusrcb;
  assign bus.sext      = w_sext;
  assign bus.iord      = w_iord;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.ir_write  = w_ir_write;
  assign bus.pc_write  = w_pc_write;
  assign bus.pcsource  = w_pcsource;
  assign bus.reg_write = w_reg_write;
  assign bus.reg_dst   = w_reg_dst;
  assign bus.wb_sel    = w_wb_sel;
  assign bus.illegal   = w_illegal;
  assign bus.bus_err   = w_bus_err;
endmodule
